write_back: RTL

- Final pipeline stage. Receives committed results from the execute stage over the existing `i_execute_to_write` interface, using its `write_in` modport.
- A register destination produces a one-cycle register-file write plus a Flags update.
- A memory destination produces a store on a waitrequest-style data bus. While the store is pending, the stage holds execute.
- A write to the Pc register asserts a one-cycle pipeline flush with the new PC.

---
 rtl/write_back_pkg.sv | 30 +++
 rtl/i_execute_to_write.sv | 27 ++
 rtl/write_back_store_port.sv | 115 +++++++++++
 rtl/write_back.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/write_back_pkg.sv
// Shared types for the write-back stage: register file, register indices and store FSM states.
package write_back_pkg;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;
    localparam int FLAGS_W   = 4;
    localparam int FLAGS_LSB = 27;

    typedef logic [31:0]           regval_t;
    typedef regval_t [NUM_REGS-1:0] regfile_t;
    typedef logic [REG_IDX_W-1:0]  reg_idx_t;

    localparam reg_idx_t Pc    = 4'd15;
    localparam reg_idx_t Flags = 4'd14;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STORE = 1'b1
    } wb_state_t;

    // Store addresses wrap modulo 2^32.
    function automatic regval_t store_address(input regval_t base, input regval_t offset);
        return base + offset;
    endfunction

    function automatic logic [FLAGS_W-1:0] flags_field(input regval_t value);
        return value[FLAGS_LSB +: FLAGS_W];
    endfunction

endpackage

// File: rtl/i_execute_to_write.sv
// Execute-to-write-back handshake; write back consumes it through the write_in modport.
interface i_execute_to_write;
    import write_back_pkg::*;

    logic        is_valid;
    regval_t     pc;
    reg_idx_t    destination;
    logic        destination_is_memory;
    logic [3:0]  flags;
    regval_t     destination_value;
    regval_t     adjustment;
    logic        has_flushed;
    logic        hold;

    modport write_in (
        input  is_valid, pc, destination, destination_is_memory, flags,
               destination_value, adjustment, has_flushed,
        output hold
    );

    modport write_out (
        output is_valid, pc, destination, destination_is_memory, flags,
               destination_value, adjustment, has_flushed,
        input  hold
    );

endinterface

// File: rtl/write_back_store_port.sv
// Store FSM on a waitrequest-style bus. Optional store timeout under WRITE_BACK_TIMEOUT_EN.
module store_port
    import write_back_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    start,
    input  regval_t start_address,
    input  regval_t start_data,
    input  logic    mem_waitrequest,
    output logic    busy,
    output regval_t mem_address,
    output regval_t mem_writedata,
    output logic    mem_write
`ifdef WRITE_BACK_TIMEOUT_EN
    ,
    output logic    bus_error
`endif
);

    wb_state_t state_q, state_d;
    regval_t   mem_address_q, mem_address_d;
    regval_t   mem_writedata_q, mem_writedata_d;
    logic      mem_write_q, mem_write_d;

`ifdef WRITE_BACK_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] count_q, count_d;
    logic        bus_error_q, bus_error_d;
    assign bus_error = bus_error_q;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

    // Next-state and output computation for the store handshake.
    always_comb begin
        state_d         = state_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        mem_write_d     = mem_write_q;
`ifdef WRITE_BACK_TIMEOUT_EN
        count_d         = count_q;
        bus_error_d     = bus_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = STORE;
                    mem_address_d   = start_address;
                    mem_writedata_d = start_data;
                    mem_write_d     = 1'b1;
`ifdef WRITE_BACK_TIMEOUT_EN
                    count_d         = 32'd0;
`endif
                end else begin
                    mem_write_d = 1'b0;
                end
            end
            STORE: begin
                if (!mem_waitrequest) begin
                    state_d     = IDLE;
                    mem_write_d = 1'b0;
`ifdef WRITE_BACK_TIMEOUT_EN
                end else if (count_q == TIMEOUT_LIMIT) begin
                    state_d     = IDLE;
                    mem_write_d = 1'b0;
                    bus_error_d = 1'b1;
                end else begin
                    count_d = count_q + 32'd1;
                end
`else
                end else begin
                    mem_write_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            mem_address_q   <= 32'd0;
            mem_writedata_q <= 32'd0;
            mem_write_q     <= 1'b0;
`ifdef WRITE_BACK_TIMEOUT_EN
            count_q         <= 32'd0;
            bus_error_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            mem_write_q     <= mem_write_d;
`ifdef WRITE_BACK_TIMEOUT_EN
            count_q         <= count_d;
            bus_error_q     <= bus_error_d;
`endif
        end
    end

    assign busy          = (state_q == STORE);
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_write     = mem_write_q;

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: register/flags writes, PC flush and stores.
// Define WRITE_BACK_TIMEOUT_EN to add the store timeout and sticky bus_error output.
module write_back
    import write_back_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  regfile_t               registers,
    i_execute_to_write.write_in    ini,
    output logic                   rf_write,
    output reg_idx_t               rf_index,
    output regval_t                rf_value,
    output logic                   flags_write,
    output logic [FLAGS_W-1:0]     flags_value,
    output regval_t                mem_address,
    output regval_t                mem_writedata,
    output logic                   mem_write,
    input  logic                   mem_waitrequest,
    output logic                   flush,
    output regval_t                flush_pc
`ifdef WRITE_BACK_TIMEOUT_EN
    ,
    output logic                   bus_error
`endif
);

    logic accept_s, drop_s, commit_s, reg_commit_s, store_start_s;
    logic is_pc_s, is_flags_s, store_busy_s;

    logic               rf_write_q, rf_write_d;
    reg_idx_t           rf_index_q, rf_index_d;
    regval_t            rf_value_q, rf_value_d;
    logic               flags_write_q, flags_write_d;
    logic [FLAGS_W-1:0] flags_value_q, flags_value_d;
    logic               flush_q, flush_d;
    regval_t            flush_pc_q, flush_pc_d;
    logic               discarding_q, discarding_d;

    // The instruction PC is carried for debug visibility only.
    logic unused_pc_s;
    assign unused_pc_s = ^ini.pc;

    assign ini.hold = reset_n && store_busy_s;

    // Accept/discard decode and next values of the register-side outputs.
    always_comb begin
        accept_s      = ini.is_valid && !ini.hold;
        drop_s        = discarding_q && !ini.has_flushed;
        commit_s      = accept_s && !drop_s;
        reg_commit_s  = commit_s && !ini.destination_is_memory;
        store_start_s = commit_s && ini.destination_is_memory;
        is_pc_s       = (ini.destination == Pc);
        is_flags_s    = (ini.destination == Flags);

        rf_write_d    = reg_commit_s && !is_pc_s;
        flags_write_d = store_start_s || (reg_commit_s && !is_flags_s);
        flush_d       = reg_commit_s && is_pc_s;

        if (reg_commit_s) begin
            rf_index_d = ini.destination;
            rf_value_d = ini.destination_value;
        end else begin
            rf_index_d = rf_index_q;
            rf_value_d = rf_value_q;
        end

        if (flags_write_d) begin
            flags_value_d = ini.flags;
        end else begin
            flags_value_d = flags_value_q;
        end

        if (flush_d) begin
            flush_pc_d = ini.destination_value;
        end else begin
            flush_pc_d = flush_pc_q;
        end

        // A new PC write re-arms discarding even if it also carried has_flushed.
        if (flush_d) begin
            discarding_d = 1'b1;
        end else if (accept_s && ini.has_flushed) begin
            discarding_d = 1'b0;
        end else begin
            discarding_d = discarding_q;
        end
    end

    // Registered register-side outputs and discard state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_q    <= 1'b0;
            rf_index_q    <= 4'd0;
            rf_value_q    <= 32'd0;
            flags_write_q <= 1'b0;
            flags_value_q <= 4'd0;
            flush_q       <= 1'b0;
            flush_pc_q    <= 32'd0;
            discarding_q  <= 1'b0;
        end else begin
            rf_write_q    <= rf_write_d;
            rf_index_q    <= rf_index_d;
            rf_value_q    <= rf_value_d;
            flags_write_q <= flags_write_d;
            flags_value_q <= flags_value_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
            discarding_q  <= discarding_d;
        end
    end

    store_port #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_store_port (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (store_start_s),
        .start_address   (store_address(registers[ini.destination], ini.adjustment)),
        .start_data      (ini.destination_value),
        .mem_waitrequest (mem_waitrequest),
        .busy            (store_busy_s),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_write       (mem_write)
`ifdef WRITE_BACK_TIMEOUT_EN
        ,
        .bus_error       (bus_error)
`endif
    );

    assign rf_write    = rf_write_q;
    assign rf_index    = rf_index_q;
    assign rf_value    = rf_value_q;
    assign flags_write = flags_write_q;
    assign flags_value = flags_value_q;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;

endmodule
